// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side access controller.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        IO_DONE
    } mem_state_t;

    // Word address that maps to the switches (read) and hex display (write).
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Active-low SRAM strobe bundle.
    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
    } strobe_t;

    localparam strobe_t STROBE_OFF = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1};

endpackage

// File: rtl/sram_access_ctrl.sv
// Sequences one CPU word request at a time onto a 1Mx16 async SRAM with a
// programmable number of wait states, and decodes one address as switch/hex I/O.
module sram_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    input  logic [15:0] Switches,
    output logic [15:0] hex_reg,
    output logic [19:0] ADDR,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [15:0] Data_write,
    input  logic [15:0] Data_read,
    output logic        Data_oe
);

    localparam logic [3:0] COUNT_LOAD = 4'(WAIT_STATES - 1);

    mem_state_t  state, state_nxt;
    logic [3:0]  count;
    logic        we_q;
    logic [15:0] wdata_q;
    strobe_t     strb, strb_nxt;
    logic        data_oe_nxt;

    // A request is only seen while idle; busy is high in every other state.
    logic accept;
    logic is_io;
    logic cur_we;
    assign accept = (state == IDLE) && req;
    assign is_io  = (addr == IO_ADDR);
    // Direction of the access being entered: the live input on the accept edge, latched afterwards.
    assign cur_we = accept ? we : we_q;

    // Next-state decode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (req) state_nxt = is_io ? IO_DONE : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (count == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            IO_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe decode from the next state, so pins change only on the clock edge.
    always_comb begin
        strb_nxt    = STROBE_OFF;
        data_oe_nxt = 1'b0;
        unique case (state_nxt)
            SETUP: begin
                strb_nxt.ce = 1'b0;
                strb_nxt.ub = 1'b0;
                strb_nxt.lb = 1'b0;
                strb_nxt.oe = cur_we;
                data_oe_nxt = cur_we;
            end
            ACCESS: begin
                strb_nxt.ce = 1'b0;
                strb_nxt.ub = 1'b0;
                strb_nxt.lb = 1'b0;
                if (we_q) begin
                    strb_nxt.we = 1'b0;
                    data_oe_nxt = 1'b1;
                end else begin
                    strb_nxt.oe = 1'b0;
                end
            end
            DONE: begin
                // Writes keep the chip selected and the bus driven one cycle past WE rising.
                if (we_q) begin
                    strb_nxt.ce = 1'b0;
                    strb_nxt.ub = 1'b0;
                    strb_nxt.lb = 1'b0;
                    data_oe_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control state, wait counter and registered handshake/strobe outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            strb    <= STROBE_OFF;
            Data_oe <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            strb    <= strb_nxt;
            Data_oe <= data_oe_nxt;
            ack     <= (state_nxt == DONE) || (state_nxt == IO_DONE);
            busy    <= (state_nxt != IDLE);
            if (state == SETUP)
                count <= COUNT_LOAD;
            else if ((state == ACCESS) && (count != 4'd0))
                count <= count - 4'd1;
        end
    end

    // Request latch, SRAM address, read-data return and hex-display register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
            ADDR    <= 20'h00000;
            rdata   <= 16'h0000;
            hex_reg <= 16'h0000;
        end else begin
            if (accept) begin
                we_q    <= we;
                wdata_q <= wdata;
                if (!is_io)
                    ADDR <= {4'h0, addr};
                else if (we)
                    hex_reg <= wdata;
                else
                    rdata <= Switches;
            end
            // Read data is captured at the end of the last ACCESS cycle while OE is still low.
            if ((state == ACCESS) && (count == 4'd0) && !we_q)
                rdata <= Data_read;
        end
    end

    assign CE         = strb.ce;
    assign UB         = strb.ub;
    assign LB         = strb.lb;
    assign OE         = strb.oe;
    assign WE         = strb.we;
    assign Data_write = wdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a small SRAM model behind the main
// instance (WAIT_STATES=2) plus two read-only instances for W=1 and W=15.
module tb_sram_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req, we;
    logic [15:0] addr, wdata, Switches;
    logic [15:0] rdata, hex_reg, Data_write, Data_read;
    logic [19:0] ADDR;
    logic        ack, busy, CE, UB, LB, OE, WE, Data_oe;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol_oe_we = 0;
    int viol_oe_drv = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_access_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .Switches(Switches), .hex_reg(hex_reg),
        .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .Data_write(Data_write), .Data_read(Data_read), .Data_oe(Data_oe)
    );

    // SRAM model: a write commits when WE rises while the chip is still selected.
    logic [15:0] mem [0:255];
    logic        wr_pend = 1'b0;
    logic [7:0]  pend_addr;
    logic [15:0] pend_data;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h7777;
        mem[8'h31] = 16'h1111;
    end

    always @(posedge Clk) begin
        if (!CE && !WE) begin
            wr_pend   <= 1'b1;
            pend_addr <= ADDR[7:0];
            pend_data <= Data_write;
        end else if (wr_pend) begin
            if (!CE) mem[pend_addr] <= pend_data;
            wr_pend <= 1'b0;
        end
    end

    assign Data_read = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hDEAD;

    // Wait-state sweep instances: reads only, fixed address, constant SRAM data.
    logic        req_sw [2];
    logic        ack_sw [2];
    logic        busy_sw [2];
    logic [15:0] rdata_sw [2];
    logic [15:0] hex_sw [2];
    logic [19:0] addr_out_sw [2];
    logic        ce_sw [2], ub_sw [2], lb_sw [2], oe_sw [2], we_sw [2], doe_sw [2];
    logic [15:0] dw_sw [2];
    logic [15:0] dr_sw [2];

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        assign dr_sw[g] = (!ce_sw[g] && !oe_sw[g]) ? 16'hC3C3 : 16'hDEAD;
        sram_access_ctrl #(.WAIT_STATES(g == 0 ? 1 : 15), .IO_ADDR(16'hFFFF)) dut_sw (
            .Clk(Clk), .Reset(Reset), .req(req_sw[g]), .we(1'b0), .addr(16'h0040),
            .wdata(16'h0000), .rdata(rdata_sw[g]), .ack(ack_sw[g]), .busy(busy_sw[g]),
            .Switches(16'h0000), .hex_reg(hex_sw[g]), .ADDR(addr_out_sw[g]),
            .CE(ce_sw[g]), .UB(ub_sw[g]), .LB(lb_sw[g]), .OE(oe_sw[g]), .WE(we_sw[g]),
            .Data_write(dw_sw[g]), .Data_read(dr_sw[g]), .Data_oe(doe_sw[g])
        );
    end

    // Bus-safety monitor across all instances.
    always @(negedge Clk) begin
        if (!OE && !WE) viol_oe_we++;
        if (Data_oe && !OE) viol_oe_drv++;
        for (int i = 0; i < 2; i++) begin
            if (!oe_sw[i] && !we_sw[i]) viol_oe_we++;
            if (doe_sw[i] && !oe_sw[i]) viol_oe_drv++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One transaction on the main instance; lat is the ack cycle counted from the accept edge.
    task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int we_low, output int strobe_low,
                        output logic [15:0] rd);
        int  k;
        bit  got;
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0; addr = 16'h0000; wdata = 16'h0000;
        k = 0; got = 1'b0; we_low = 0; strobe_low = 0; rd = 16'h0000;
        while (!got && k < 50) begin
            if (!WE) we_low++;
            if (!CE || !UB || !LB || !OE || !WE) strobe_low++;
            if (ack) begin
                got = 1'b1;
                rd  = rdata;
            end else begin
                tick();
                k++;
            end
        end
        lat = got ? k + 1 : -1;
        tick();
    endtask

    task automatic sweep_read(input int i, output int lat, output logic [15:0] rd);
        int k;
        bit got;
        req_sw[i] = 1'b1;
        tick();
        req_sw[i] = 1'b0;
        k = 0; got = 1'b0; rd = 16'h0000;
        while (!got && k < 50) begin
            if (ack_sw[i]) begin
                got = 1'b1;
                rd  = rdata_sw[i];
            end else begin
                tick();
                k++;
            end
        end
        lat = got ? k + 1 : -1;
        tick();
    endtask

    // Hold req high and measure the distance between the first two acks.
    task automatic back_to_back(input logic [15:0] a, output int spacing);
        int t [2];
        int n;
        int k;
        req = 1'b1; we = 1'b0; addr = a; wdata = 16'h0000;
        n = 0; k = 0;
        while (n < 2 && k < 60) begin
            tick();
            k++;
            if (ack) begin
                t[n] = cyc;
                n++;
            end
        end
        req = 1'b0;
        spacing = (n == 2) ? t[1] - t[0] : -1;
        k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        tick();
    endtask

    initial begin
        int lat, wl, sl, acks, sp;
        logic [15:0] rd;

        Reset = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
        Switches = 16'h0000;
        req_sw[0] = 1'b0; req_sw[1] = 1'b0;
        tick();
        tick();
        check("rst_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        check("rst_handshake", {ack, busy, Data_oe}, 3'b000);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_hex", hex_reg, 16'h0000);
        check("rst_addr", ADDR, 20'h00000);
        Reset = 1'b0;
        tick();

        // Reset in the middle of a write must abort it cleanly.
        req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'hAAAA;
        tick();
        req = 1'b0;
        tick();
        check("abort_in_access", {WE, Data_oe}, 2'b01);
        Reset = 1'b1;
        tick();
        check("abort_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        check("abort_handshake", {ack, busy, Data_oe}, 3'b000);
        Reset = 1'b0;
        tick();
        check("abort_no_ack", ack, 1'b0);
        tick();
        xfer(1'b0, 16'h0010, 16'h0000, lat, wl, sl, rd);
        check("abort_word_kept", rd, 16'h7777);

        // SRAM write then read back.
        xfer(1'b1, 16'h0020, 16'h1234, lat, wl, sl, rd);
        check("wr_latency", lat, 4);
        check("wr_we_low_cycles", wl, 2);
        check("wr_addr", ADDR, 20'h00020);
        xfer(1'b0, 16'h0020, 16'h0000, lat, wl, sl, rd);
        check("rd_latency", lat, 4);
        check("rd_data", rd, 16'h1234);
        check("rd_we_low_cycles", wl, 0);

        // Memory-mapped I/O.
        xfer(1'b1, 16'hFFFF, 16'hBEEF, lat, wl, sl, rd);
        check("io_wr_latency", lat, 1);
        check("io_wr_hex", hex_reg, 16'hBEEF);
        check("io_wr_no_strobe", sl, 0);
        check("io_addr_untouched", ADDR, 20'h00020);
        Switches = 16'h00A5;
        xfer(1'b0, 16'hFFFF, 16'h0000, lat, wl, sl, rd);
        check("io_rd_latency", lat, 1);
        check("io_rd_data", rd, 16'h00A5);
        check("io_rd_no_strobe", sl, 0);
        check("io_rd_hex_kept", hex_reg, 16'hBEEF);

        // A request pulsed while busy is dropped.
        req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'hAAAA;
        tick();
        req = 1'b0;
        tick();
        check("busy_mid_access", busy, 1'b1);
        req = 1'b1; addr = 16'h0031; wdata = 16'h5555;
        tick();
        req = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack) acks++;
        end
        check("busy_one_ack", acks, 1);
        xfer(1'b0, 16'h0031, 16'h0000, lat, wl, sl, rd);
        check("busy_req_dropped", rd, 16'h1111);
        xfer(1'b0, 16'h0030, 16'h0000, lat, wl, sl, rd);
        check("busy_first_done", rd, 16'hAAAA);

        // Wait-state sweep.
        sweep_read(0, lat, rd);
        check("w1_latency", lat, 3);
        check("w1_data", rd, 16'hC3C3);
        sweep_read(1, lat, rd);
        check("w15_latency", lat, 17);
        check("w15_data", rd, 16'hC3C3);

        // Continuous req: SRAM and I/O ack spacing.
        back_to_back(16'h0020, sp);
        check("b2b_sram_spacing", sp, 5);
        check("b2b_sram_data", rdata, 16'h1234);
        back_to_back(16'hFFFF, sp);
        check("b2b_io_spacing", sp, 2);

        check("oe_we_exclusive", viol_oe_we, 0);
        check("drive_vs_oe_exclusive", viol_oe_drv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
